seq_arith_unit: RTL

//  Multi-op synchronous arithmetic unit: ADD, SUB, unsigned MUL, signed MUL on W-bit operands.

---
 rtl/seq_arith_unit_pkg.sv | 20 ++
 rtl/shift_add_step.sv | 27 ++
 rtl/seq_arith_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_arith_unit_pkg.sv
// Shared definitions for the sequential arithmetic unit: opcode and FSM
// state encodings used by the top level and by the testbench.
package seq_arith_unit_pkg;

  // Operation selector as presented on opSel.
  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MULU = 2'b10,
    OP_MULS = 2'b11
  } arithOp_e;

  // Control FSM states: accept, compute, hold result for the consumer.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } arithState_e;

endpackage

// File: rtl/shift_add_step.sv
// One combinational iteration of the shift-add multiplier: conditionally add
// the multiplicand into the accumulator, then advance multiplicand (left) and
// multiplier (right) by one bit position.
module shift_add_step #(
  parameter int dataWidth = 8
) (
  input  logic [2*dataWidth-1:0] accIn,
  input  logic [2*dataWidth-1:0] mcandIn,
  input  logic [dataWidth-1:0]   mplierIn,
  output logic [2*dataWidth-1:0] accOut,
  output logic [2*dataWidth-1:0] mcandOut,
  output logic [dataWidth-1:0]   mplierOut
);

  // Single partial-product accumulation and operand shift.
  always_comb begin
    accOut    = accIn;
    mcandOut  = mcandIn << 1;
    mplierOut = mplierIn >> 1;
    if (mplierIn[0]) begin
      accOut = accIn + mcandIn;
    end else begin
      accOut = accIn;
    end
  end

endmodule

// File: rtl/seq_arith_unit.sv
// Multi-op sequential arithmetic unit: ADD/SUB in one compute cycle,
// unsigned and signed multiply by iterative shift-add over dataWidth cycles.
// valid/ready handshake on input and output; one operation in flight.
module seq_arith_unit
  import seq_arith_unit_pkg::*;
#(
  parameter int dataWidth = 8
) (
  input  logic                   arithClock,
  input  logic                   resetNeg,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [1:0]             opSel,
  input  logic [dataWidth-1:0]   numA,
  input  logic [dataWidth-1:0]   numB,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [2*dataWidth-1:0] result,
  output logic                   carryOut,
  output logic                   overflowBit
);

  localparam int W  = dataWidth;
  localparam int CW = $clog2(dataWidth + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(dataWidth - 1);

  arithState_e stateR, stateNextS;
  arithOp_e    opR;

  logic [W-1:0]   aR, bR;
  logic [2*W-1:0] accR, mcandR;
  logic [W-1:0]   mplierR;
  logic           negR;
  logic [CW-1:0]  countR;

  logic [2*W-1:0] resultR;
  logic           carryR, overflowR, outValidR;

  logic [2*W-1:0] accStepS, mcandStepS;
  logic [W-1:0]   mplierStepS;
  logic [2*W-1:0] productS;
  logic           mulOvfS;
  logic [W:0]     addSumS, subSumS;
  logic           addOvfS, subOvfS;
  logic [W-1:0]   magAS, magBS;
  logic           lastStepS, isMulS;

  shift_add_step #(.dataWidth(W)) stepUnit (
    .accIn    (accR),
    .mcandIn  (mcandR),
    .mplierIn (mplierR),
    .accOut   (accStepS),
    .mcandOut (mcandStepS),
    .mplierOut(mplierStepS)
  );

  assign inReady     = (stateR == ST_IDLE);
  assign outValid    = outValidR;
  assign result      = resultR;
  assign carryOut    = carryR;
  assign overflowBit = overflowR;

  // Operand magnitudes at capture; only MULS strips the sign.
  always_comb begin
    magAS = numA;
    magBS = numB;
    if (opSel == OP_MULS && numA[W-1]) begin
      magAS = ~numA + {{(W-1){1'b0}}, 1'b1};
    end else begin
      magAS = numA;
    end
    if (opSel == OP_MULS && numB[W-1]) begin
      magBS = ~numB + {{(W-1){1'b0}}, 1'b1};
    end else begin
      magBS = numB;
    end
  end

  // Add/sub results and signed-overflow flags from the captured operands.
  always_comb begin
    addSumS = {1'b0, aR} + {1'b0, bR};
    subSumS = {1'b0, aR} + {1'b0, ~bR} + {{W{1'b0}}, 1'b1};
    addOvfS = (aR[W-1] == bR[W-1]) && (addSumS[W-1] != aR[W-1]);
    subOvfS = (aR[W-1] != bR[W-1]) && (subSumS[W-1] != aR[W-1]);
  end

  // Final product with sign fix-up and overflow classification.
  always_comb begin
    productS  = accStepS;
    lastStepS = (countR == LAST_STEP);
    isMulS    = (opR == OP_MULU) || (opR == OP_MULS);
    if (negR) begin
      productS = ~accStepS + {{(2*W-1){1'b0}}, 1'b1};
    end else begin
      productS = accStepS;
    end
    if (opR == OP_MULS) begin
      mulOvfS = (productS[2*W-1:W] != {W{productS[W-1]}});
    end else begin
      mulOvfS = (productS[2*W-1:W] != {W{1'b0}});
    end
  end

  // Control state register.
  always_ff @(posedge arithClock or negedge resetNeg) begin
    if (!resetNeg) begin
      stateR <= ST_IDLE;
    end else begin
      stateR <= stateNextS;
    end
  end

  // Next-state decode: IDLE -> CALC -> DONE -> IDLE.
  always_comb begin
    stateNextS = stateR;
    case (stateR)
      ST_IDLE: begin
        if (inValid) begin
          stateNextS = ST_CALC;
        end else begin
          stateNextS = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (!isMulS || lastStepS) begin
          stateNextS = ST_DONE;
        end else begin
          stateNextS = ST_CALC;
        end
      end
      ST_DONE: begin
        if (outReady) begin
          stateNextS = ST_IDLE;
        end else begin
          stateNextS = ST_DONE;
        end
      end
      default: stateNextS = ST_IDLE;
    endcase
  end

  // Output valid tracks entry into and residence in DONE.
  always_ff @(posedge arithClock or negedge resetNeg) begin
    if (!resetNeg) begin
      outValidR <= 1'b0;
    end else begin
      outValidR <= (stateNextS == ST_DONE);
    end
  end

  // Operand capture, multiply iteration and result/flag registers.
  always_ff @(posedge arithClock or negedge resetNeg) begin
    if (!resetNeg) begin
      opR       <= OP_ADD;
      aR        <= {W{1'b0}};
      bR        <= {W{1'b0}};
      accR      <= {(2*W){1'b0}};
      mcandR    <= {(2*W){1'b0}};
      mplierR   <= {W{1'b0}};
      negR      <= 1'b0;
      countR    <= {CW{1'b0}};
      resultR   <= {(2*W){1'b0}};
      carryR    <= 1'b0;
      overflowR <= 1'b0;
    end else begin
      case (stateR)
        ST_IDLE: begin
          if (inValid) begin
            opR     <= arithOp_e'(opSel);
            aR      <= numA;
            bR      <= numB;
            accR    <= {(2*W){1'b0}};
            mcandR  <= {{W{1'b0}}, magAS};
            mplierR <= magBS;
            negR    <= (opSel == OP_MULS) && (numA[W-1] ^ numB[W-1]);
            countR  <= {CW{1'b0}};
          end
        end
        ST_CALC: begin
          case (opR)
            OP_ADD: begin
              resultR   <= {{W{1'b0}}, addSumS[W-1:0]};
              carryR    <= addSumS[W];
              overflowR <= addOvfS;
            end
            OP_SUB: begin
              resultR   <= {{W{1'b0}}, subSumS[W-1:0]};
              carryR    <= subSumS[W];
              overflowR <= subOvfS;
            end
            OP_MULU, OP_MULS: begin
              accR    <= accStepS;
              mcandR  <= mcandStepS;
              mplierR <= mplierStepS;
              countR  <= countR + {{(CW-1){1'b0}}, 1'b1};
              if (lastStepS) begin
                resultR   <= productS;
                carryR    <= 1'b0;
                overflowR <= mulOvfS;
              end
            end
            default: begin
              resultR <= resultR;
            end
          endcase
        end
        ST_DONE: begin
          resultR <= resultR;
        end
        default: begin
          countR <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule
